rgb_led_arbiter: RTL



---
 rtl/rgb_led_arbiter.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/rgb_led_arbiter.sv
// rgb_led_arbiter: lends the RGB LED to one of three status requesters at a time.
// Arbitration uses fixed priority with a minimum hold time and happens only on
// PWM period boundaries. The block drives the PWM and enable pins of SB_RGBA_DRV.
module rgb_led_arbiter #(
    parameter int CLK_DIV       = 48,
    parameter int BLINK_PERIODS = 64,
    parameter int HOLD_PERIODS  = 16
) (
    input  logic        hw_clk,
    input  logic        rst,
    input  logic [2:0]  req,
    input  logic [23:0] color0,
    input  logic [23:0] color1,
    input  logic [23:0] color2,
    input  logic [2:0]  blink,
    output logic [2:0]  grant,
    output logic        led_en,
    output logic        pwm_red,
    output logic        pwm_green,
    output logic        pwm_blue
);

    localparam int PRE_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int HOLD_W = $clog2(HOLD_PERIODS + 1);
    localparam int BLK_W  = (BLINK_PERIODS > 1) ? $clog2(BLINK_PERIODS) : 1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_OWN  = 1'b1
    } state_t;

    state_t              r_state;
    logic [PRE_W-1:0]    r_pre;
    logic [7:0]          r_pwm_cnt;
    logic [HOLD_W-1:0]   r_hold;
    logic [BLK_W-1:0]    r_blink_cnt;
    logic                r_blink_on;
    logic                r_blink_q;
    logic [1:0]          r_owner;
    logic [2:0]          r_grant;
    logic                r_led_en;
    logic [7:0]          r_dr, r_dg, r_db;
    logic                r_pwm_red, r_pwm_green, r_pwm_blue;

    logic                w_tick;
    logic                w_pb;
    logic                w_req_any;
    logic [1:0]          w_sel;
    logic [23:0]         w_sel_color;
    logic                w_sel_blink;
    logic [23:0]         w_own_color;
    logic                w_own_blink;
    logic                w_own_req;
    logic                w_release;
    logic                w_new_grant;
    logic                w_lit;

    assign w_tick    = (r_pre == PRE_W'(CLK_DIV - 1));
    assign w_pb      = w_tick && (r_pwm_cnt == 8'hFF);
    assign w_req_any = |req;

    // Lowest-index requester wins; sel is meaningless when nobody requests.
    always_comb begin
        w_sel = 2'd0;
        if (req[0])      w_sel = 2'd0;
        else if (req[1]) w_sel = 2'd1;
        else if (req[2]) w_sel = 2'd2;
    end

    // Colour/blink of the candidate and of the current owner.
    always_comb begin
        w_sel_color = color0;
        w_sel_blink = blink[0];
        w_own_color = color0;
        w_own_blink = blink[0];
        w_own_req   = req[0];
        case (w_sel)
            2'd1:    begin w_sel_color = color1; w_sel_blink = blink[1]; end
            2'd2:    begin w_sel_color = color2; w_sel_blink = blink[2]; end
            default: begin w_sel_color = color0; w_sel_blink = blink[0]; end
        endcase
        case (r_owner)
            2'd1:    begin w_own_color = color1; w_own_blink = blink[1]; w_own_req = req[1]; end
            2'd2:    begin w_own_color = color2; w_own_blink = blink[2]; w_own_req = req[2]; end
            default: begin w_own_color = color0; w_own_blink = blink[0]; w_own_req = req[0]; end
        endcase
    end

    // The owner lets go once its hold is spent and it either stopped asking
    // or a higher-priority requester is waiting.
    assign w_release   = (r_hold == '0) && (!w_own_req || (w_req_any && (w_sel < r_owner)));
    assign w_new_grant = w_req_any && ((r_state == S_IDLE) || w_release);

    // Prescaler and 8-bit PWM step counter.
    always_ff @(posedge hw_clk or posedge rst) begin
        if (rst) begin
            r_pre     <= '0;
            r_pwm_cnt <= 8'd0;
        end else if (w_tick) begin
            r_pre     <= '0;
            r_pwm_cnt <= r_pwm_cnt + 8'd1;
        end else begin
            r_pre     <= r_pre + PRE_W'(1);
        end
    end

    // Grant FSM: all ownership, hold, blink and duty state moves only on a period boundary.
    always_ff @(posedge hw_clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_owner     <= 2'd0;
            r_grant     <= 3'b000;
            r_led_en    <= 1'b0;
            r_hold      <= '0;
            r_blink_cnt <= '0;
            r_blink_on  <= 1'b0;
            r_blink_q   <= 1'b0;
            r_dr        <= 8'd0;
            r_dg        <= 8'd0;
            r_db        <= 8'd0;
        end else if (w_pb) begin
            case (r_state)
                S_IDLE, S_OWN: begin
                    if (w_new_grant) begin
                        r_state     <= S_OWN;
                        r_owner     <= w_sel;
                        r_grant     <= 3'b001 << w_sel;
                        r_led_en    <= 1'b1;
                        r_hold      <= HOLD_W'(HOLD_PERIODS);
                        r_blink_cnt <= '0;
                        r_blink_on  <= 1'b1;
                        r_blink_q   <= w_sel_blink;
                        {r_dr, r_dg, r_db} <= w_sel_color;
                    end else if (r_state == S_OWN && w_release) begin
                        r_state  <= S_IDLE;
                        r_grant  <= 3'b000;
                        r_led_en <= 1'b0;
                    end else if (r_state == S_OWN) begin
                        // Owner kept: count hold down and refresh duty at the boundary only.
                        if (r_hold != '0) r_hold <= r_hold - HOLD_W'(1);
                        r_blink_q <= w_own_blink;
                        {r_dr, r_dg, r_db} <= w_own_color;
                        if (r_blink_cnt == BLK_W'(BLINK_PERIODS - 1)) begin
                            r_blink_cnt <= '0;
                            r_blink_on  <= ~r_blink_on;
                        end else begin
                            r_blink_cnt <= r_blink_cnt + BLK_W'(1);
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign w_lit = (r_state == S_OWN) && (r_blink_on || !r_blink_q);

    // Registered PWM compare, one cycle behind the counter and duty registers.
    always_ff @(posedge hw_clk or posedge rst) begin
        if (rst) begin
            r_pwm_red   <= 1'b0;
            r_pwm_green <= 1'b0;
            r_pwm_blue  <= 1'b0;
        end else begin
            r_pwm_red   <= w_lit && (r_pwm_cnt < r_dr);
            r_pwm_green <= w_lit && (r_pwm_cnt < r_dg);
            r_pwm_blue  <= w_lit && (r_pwm_cnt < r_db);
        end
    end

    assign grant     = r_grant;
    assign led_en    = r_led_en;
    assign pwm_red   = r_pwm_red;
    assign pwm_green = r_pwm_green;
    assign pwm_blue  = r_pwm_blue;

endmodule
